motion_detect_ctrl: RTL and testbench
=====================================

// Module: motion_detect_ctrl
// PURPOSE
//  Frame-level sequencer for the diff detector / diff pixel counter pair.
//  - Tracks the pixel stream and issues the per-frame frame_done clear pulse.
//  - Samples the finished frame's diff count and compares it to a threshold.
//  - Runs a hysteresis FSM that drives a debounced motion flag to the tracking logic.
// PARAMETERS
//  H_RES          320                      active pixels per line
//  V_RES          240                      active lines per frame
//  CNT_W          $clog2(H_RES*V_RES)      diff count / threshold width
//  WARMUP_FRAMES  2                        frames discarded after reset/enable (min 1)
//  ON_FRAMES      3                        consecutive hit frames to assert motion (min 1)
//  OFF_FRAMES     8                        consecutive miss frames to drop motion (min 1)
// PORTS
//  clk             in   1                      system clock
//  reset           in   1                      async, active-high
//  enable          in   1                      evaluation enable
//  threshold       in   CNT_W                  hit if frame count >= threshold
//  pix_valid       in   1                      pixel accepted this cycle
//  pix_x           in   $clog2(H_RES)          pixel column
//  pix_y           in   $clog2(V_RES)          pixel row
//  diff_pixel_cnt  in   CNT_W                  running count from the counter
//  frame_done      out  1                      1-cycle pulse; clears the counter
//  last_cnt        out  CNT_W                  count of the last completed frame
//  motion          out  1                      debounced motion flag
//  state_o         out  3                      FSM state encoding, debug
//  irq             out  1                      see CONFIGURATION
//  irq_clr         in   1                      see CONFIGURATION
// BEHAVIOUR
//  Reset values: frame_done=0, last_cnt=0, motion=0, irq=0, state=WARMUP.
//    All internal counters are 0.
//  End of frame (eof): pix_valid && pix_x==H_RES-1 && pix_y==V_RES-1.
//    Out-of-range coordinates are ignored.
//  frame_done is eof delayed by exactly 1 cycle (registered).
//    The counter's update for the last pixel is then visible on diff_pixel_cnt.
//  On the frame_done cycle:
//    - last_cnt <= diff_pixel_cnt.
//    - hit = (diff_pixel_cnt >= threshold). threshold is sampled only on this cycle.
//  The counter clears with priority on frame_done. A diff on a pixel accepted in
//    the frame_done cycle is lost. Sources must give >=1 blanking cycle after eof.
//  frame_done is generated regardless of enable, so the counter stays per-frame.
//  FSM: advances only on frame_done && enable.
//    WARMUP : count frames; after WARMUP_FRAMES -> STILL. Frame is never evaluated.
//    STILL  : hit -> ARMING with run=1. If ON_FRAMES==1 -> MOTION directly.
//    ARMING : hit -> run++, reaching ON_FRAMES -> MOTION; miss -> STILL, run=0.
//    MOTION : miss -> COOLING with run=1. If OFF_FRAMES==1 -> STILL directly.
//    COOLING: miss -> run++, reaching OFF_FRAMES -> STILL; hit -> MOTION, run=0.
//  motion is registered: 1 in MOTION and COOLING, 0 otherwise.
//    It changes on the cycle after the deciding frame_done.
//  enable low:
//    - FSM returns to WARMUP next cycle; motion=0; run and warm-up counts cleared.
//    - last_cnt still updates on every frame_done.
//  enable rising mid-frame: the partial frame is consumed by WARMUP (hence min 1).
//  threshold==0: every frame is a hit.
//  threshold > H_RES*V_RES: no frame is ever a hit.
//  Run counters saturate and never wrap. Async reset mid-frame returns to the reset state.
// CONFIGURATION
//  MOTION_IRQ_EN defined:
//    - irq is a sticky level, set the cycle motion rises (0->1).
//    - irq_clr clears it; set wins when set and clear coincide.
//  MOTION_IRQ_EN undefined: irq tied 0; irq_clr ignored; no irq flop.
// TESTING (bench overrides H_RES=4, V_RES=2, WARMUP=1, ON=2, OFF=2)
//  1. Reset, then stream 8 pixels -> frame_done pulses once, 1 cycle after (3,1).
//     state WARMUP->STILL.
//  2. threshold=3, counter driven to 3 at eof for 2 frames
//     -> STILL->ARMING->MOTION; motion=1 one cycle after the 2nd frame_done;
//     last_cnt=3.
//  3. In MOTION: miss, hit, miss, miss -> COOLING, MOTION, COOLING, STILL;
//     motion=0 only after the 4th frame.
//  4. Pixel at (3,1) followed next cycle by pix_valid at (0,0)
//     -> frame_done still exactly 1 cycle; last_cnt holds the pre-clear value.
//  5. enable dropped in MOTION -> next cycle state=WARMUP, motion=0;
//     re-enabled mid-frame -> that frame is discarded.
//  6. MOTION_IRQ_EN: motion rises with irq_clr high the same cycle -> irq=1;
//     irq_clr next cycle -> irq=0. Without the macro, irq stays 0.

Source files
------------

// File: rtl/motion_detect_ctrl.sv
// motion_detect_ctrl
// Frame-level sequencer for the diff detector / diff pixel counter pair.
// It watches the pixel stream for the last pixel of a frame and pulses
// frame_done one cycle later, which clears the external counter. On that
// cycle it latches the frame's diff count and compares it to the threshold.
// A hysteresis FSM turns hit/miss frames into a debounced motion flag.
//
// Optional feature: define MOTION_IRQ_EN to add a sticky interrupt that is
// set when motion rises and cleared by irq_clr. Without the macro, irq is
// tied low and irq_clr is ignored.
module motion_detect_ctrl #(
  parameter int H_RES         = 320,
  parameter int V_RES         = 240,
  parameter int CNT_W         = $clog2(H_RES * V_RES),
  parameter int WARMUP_FRAMES = 2,
  parameter int ON_FRAMES     = 3,
  parameter int OFF_FRAMES    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [CNT_W-1:0]         threshold,
  input  logic                     pix_valid,
  input  logic [$clog2(H_RES)-1:0] pix_x,
  input  logic [$clog2(V_RES)-1:0] pix_y,
  input  logic [CNT_W-1:0]         diff_pixel_cnt,
  output logic                     frame_done,
  output logic [CNT_W-1:0]         last_cnt,
  output logic                     motion,
  output logic [2:0]               state_o,
  output logic                     irq,
  input  logic                     irq_clr
);

  localparam int X_W     = $clog2(H_RES);
  localparam int Y_W     = $clog2(V_RES);
  localparam int MAX_RUN = (ON_FRAMES > OFF_FRAMES) ? ON_FRAMES : OFF_FRAMES;
  localparam int RUN_W   = $clog2(MAX_RUN + 1);
  localparam int WARM_W  = $clog2(WARMUP_FRAMES + 1);

  localparam logic [X_W-1:0]    X_LAST    = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(V_RES - 1);
  localparam logic [RUN_W-1:0]  ON_LAST   = RUN_W'(ON_FRAMES - 1);
  localparam logic [RUN_W-1:0]  OFF_LAST  = RUN_W'(OFF_FRAMES - 1);
  localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(MAX_RUN);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_FRAMES - 1);

  localparam logic [2:0] WARMUP  = 3'd0;
  localparam logic [2:0] STILL   = 3'd1;
  localparam logic [2:0] ARMING  = 3'd2;
  localparam logic [2:0] MOTION  = 3'd3;
  localparam logic [2:0] COOLING = 3'd4;

  logic              eof;
  logic              hit;
  logic [2:0]        state;
  logic [2:0]        state_next;
  logic [RUN_W-1:0]  run;
  logic [RUN_W-1:0]  run_next;
  logic [WARM_W-1:0] warm_cnt;
  logic [WARM_W-1:0] warm_next;
  logic              motion_next;

  // last accepted pixel of the frame; out-of-range coordinates never match
  assign eof = pix_valid && (pix_x == X_LAST) && (pix_y == Y_LAST);

  // only meaningful on the frame_done cycle, which is the sole place it is used
  assign hit = (diff_pixel_cnt >= threshold);

  // frame_done lags eof by one cycle so the last pixel's diff is already counted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= eof;
    end
  end

  // keep the finished frame's count, whether or not evaluation is enabled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_cnt <= '0;
    end else if (frame_done) begin
      last_cnt <= diff_pixel_cnt;
    end
  end

  // hysteresis next-state logic; enable low forces a fresh warm-up
  always_comb begin
    state_next = state;
    run_next   = run;
    warm_next  = warm_cnt;
    if (!enable) begin
      state_next = WARMUP;
      run_next   = '0;
      warm_next  = '0;
    end else if (frame_done) begin
      case (state)
        WARMUP: begin
          if (warm_cnt >= WARM_LAST) begin
            state_next = STILL;
            warm_next  = '0;
          end else begin
            warm_next = warm_cnt + 1'b1;
          end
        end
        STILL: begin
          if (hit) begin
            if (ON_FRAMES == 1) begin
              state_next = MOTION;
              run_next   = '0;
            end else begin
              state_next = ARMING;
              run_next   = RUN_W'(1);
            end
          end
        end
        ARMING: begin
          if (!hit) begin
            state_next = STILL;
            run_next   = '0;
          end else if (run >= ON_LAST) begin
            state_next = MOTION;
            run_next   = '0;
          end else if (run != RUN_MAX) begin
            run_next = run + 1'b1;
          end
        end
        MOTION: begin
          if (!hit) begin
            if (OFF_FRAMES == 1) begin
              state_next = STILL;
              run_next   = '0;
            end else begin
              state_next = COOLING;
              run_next   = RUN_W'(1);
            end
          end
        end
        COOLING: begin
          if (hit) begin
            state_next = MOTION;
            run_next   = '0;
          end else if (run >= OFF_LAST) begin
            state_next = STILL;
            run_next   = '0;
          end else if (run != RUN_MAX) begin
            run_next = run + 1'b1;
          end
        end
        default: begin
          state_next = WARMUP;
          run_next   = '0;
          warm_next  = '0;
        end
      endcase
    end
  end

  assign motion_next = (state_next == MOTION) || (state_next == COOLING);

  // register FSM state, run/warm-up counters and the motion flag together
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= WARMUP;
      run      <= '0;
      warm_cnt <= '0;
      motion   <= 1'b0;
    end else begin
      state    <= state_next;
      run      <= run_next;
      warm_cnt <= warm_next;
      motion   <= motion_next;
    end
  end

  assign state_o = state;

`ifdef MOTION_IRQ_EN
  logic irq_q;

  // sticky flag set on a motion rise; a new rise beats a simultaneous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else if (motion_next && !motion) begin
      irq_q <= 1'b1;
    end else if (irq_clr) begin
      irq_q <= 1'b0;
    end
  end

  assign irq = irq_q;
`else
  logic unused_irq_clr;
  assign unused_irq_clr = irq_clr;
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_motion_detect_ctrl.sv
// tb_motion_detect_ctrl
// Directed bench for motion_detect_ctrl with a small 4x2 frame.
// Expected post-frame results are queued when a frame's last pixel is driven
// and compared on the cycle after the matching frame_done pulse.
module tb_motion_detect_ctrl;

  localparam logic [2:0] ST_WARMUP  = 3'd0;
  localparam logic [2:0] ST_STILL   = 3'd1;
  localparam logic [2:0] ST_ARMING  = 3'd2;
  localparam logic [2:0] ST_MOTION  = 3'd3;
  localparam logic [2:0] ST_COOLING = 3'd4;

`ifdef MOTION_IRQ_EN
  localparam logic IRQ_EN = 1'b1;
`else
  localparam logic IRQ_EN = 1'b0;
`endif

  typedef struct packed {
    logic [2:0] cnt;
    logic [2:0] st;
    logic       mot;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [2:0] threshold;
  logic       pix_valid;
  logic [1:0] pix_x;
  logic [0:0] pix_y;
  logic [2:0] diff_pixel_cnt;
  logic       frame_done;
  logic [2:0] last_cnt;
  logic       motion;
  logic [2:0] state_o;
  logic       irq;
  logic       irq_clr;

  exp_t sb[$];
  logic pending;
  int   assert_cnt;
  int   fail_cnt;

  motion_detect_ctrl #(
    .H_RES(4),
    .V_RES(2),
    .WARMUP_FRAMES(1),
    .ON_FRAMES(2),
    .OFF_FRAMES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .threshold(threshold),
    .pix_valid(pix_valid),
    .pix_x(pix_x),
    .pix_y(pix_y),
    .diff_pixel_cnt(diff_pixel_cnt),
    .frame_done(frame_done),
    .last_cnt(last_cnt),
    .motion(motion),
    .state_o(state_o),
    .irq(irq),
    .irq_clr(irq_clr)
  );

  // free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // hard stop in case the sequence ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assert_cnt++;
    assert (observed === expected) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // compare queued expectations one cycle after each frame_done pulse
  task automatic checkOutput();
    exp_t e;
    if (pending) begin
      pending = 1'b0;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("frame_done_width", frame_done, 0);
        chk("last_cnt", last_cnt, e.cnt);
        chk("state", state_o, e.st);
        chk("motion", motion, e.mot);
      end
    end
    if (frame_done) begin
      chk("frame_done_expected", (sb.size() != 0), 1);
      pending = 1'b1;
    end
  endtask

  // drive one cycle of pixel input, then sample on the next falling edge
  task automatic applyStimulus(input logic v, input logic [1:0] x, input logic [0:0] y);
    pix_valid = v;
    pix_x     = x;
    pix_y     = y;
    @(negedge clk);
    checkOutput();
  endtask

  // stream pixels first..last of a frame; queue expectations at the last pixel
  task automatic streamRange(input int first, input int last, input logic [2:0] cnt,
                             input logic [2:0] exp_st, input logic exp_mot);
    exp_t e;
    diff_pixel_cnt = cnt;
    for (int i = first; i <= last; i++) begin
      if (i == 7) begin
        e.cnt = cnt;
        e.st  = exp_st;
        e.mot = exp_mot;
        sb.push_back(e);
      end
      applyStimulus(1'b1, 2'(i % 4), 1'(i / 4));
      if (i == 7) chk("frame_done_after_eof", frame_done, 1);
    end
  endtask

  task automatic sendFrame(input logic [2:0] cnt, input logic [2:0] exp_st, input logic exp_mot);
    streamRange(0, 7, cnt, exp_st, exp_mot);
    applyStimulus(1'b0, 2'd0, 1'd0);
    applyStimulus(1'b0, 2'd0, 1'd0);
  endtask

  initial begin
    assert_cnt     = 0;
    fail_cnt       = 0;
    pending        = 1'b0;
    reset          = 1'b1;
    enable         = 1'b0;
    threshold      = 3'd3;
    pix_valid      = 1'b0;
    pix_x          = 2'd0;
    pix_y          = 1'd0;
    diff_pixel_cnt = 3'd0;
    irq_clr        = 1'b0;

    // reset state
    #12;
    chk("rst_frame_done", frame_done, 0);
    chk("rst_last_cnt", last_cnt, 0);
    chk("rst_motion", motion, 0);
    chk("rst_state", state_o, ST_WARMUP);
    chk("rst_irq", irq, 0);
    @(negedge clk);
    reset  = 1'b0;
    enable = 1'b1;
    $display("[TB] warm-up frame");
    sendFrame(3'd0, ST_STILL, 1'b0);

    $display("[TB] two hit frames raise motion");
    sendFrame(3'd3, ST_ARMING, 1'b0);
    sendFrame(3'd3, ST_MOTION, 1'b1);
    chk("irq_after_rise", irq, IRQ_EN);

    $display("[TB] miss/hit/miss/miss hysteresis");
    sendFrame(3'd1, ST_COOLING, 1'b1);
    sendFrame(3'd3, ST_MOTION, 1'b1);
    sendFrame(3'd0, ST_COOLING, 1'b1);
    sendFrame(3'd2, ST_STILL, 1'b0);

    $display("[TB] back-to-back frames without blanking");
    streamRange(0, 7, 3'd3, ST_ARMING, 1'b0);
    applyStimulus(1'b1, 2'd0, 1'd0);
    diff_pixel_cnt = 3'd0;
    applyStimulus(1'b1, 2'd1, 1'd0);
    chk("last_cnt_pre_clear", last_cnt, 3);
    chk("no_second_pulse", frame_done, 0);
    streamRange(2, 7, 3'd3, ST_MOTION, 1'b1);
    applyStimulus(1'b0, 2'd0, 1'd0);
    applyStimulus(1'b0, 2'd0, 1'd0);

    $display("[TB] enable drop and mid-frame re-enable");
    enable = 1'b0;
    applyStimulus(1'b0, 2'd0, 1'd0);
    chk("disable_state", state_o, ST_WARMUP);
    chk("disable_motion", motion, 0);
    sendFrame(3'd5, ST_WARMUP, 1'b0);
    streamRange(0, 3, 3'd3, ST_WARMUP, 1'b0);
    enable = 1'b1;
    streamRange(4, 7, 3'd3, ST_STILL, 1'b0);
    applyStimulus(1'b0, 2'd0, 1'd0);
    applyStimulus(1'b0, 2'd0, 1'd0);
    sendFrame(3'd3, ST_ARMING, 1'b0);

    $display("[TB] threshold boundaries");
    threshold = 3'd0;
    sendFrame(3'd0, ST_MOTION, 1'b1);
    threshold = 3'd7;
    sendFrame(3'd6, ST_COOLING, 1'b1);
    sendFrame(3'd7, ST_MOTION, 1'b1);

    $display("[TB] interrupt set/clear");
    sendFrame(3'd0, ST_COOLING, 1'b1);
    sendFrame(3'd0, ST_STILL, 1'b0);
    chk("irq_before_clr", irq, IRQ_EN);
    irq_clr = 1'b1;
    applyStimulus(1'b0, 2'd0, 1'd0);
    irq_clr = 1'b0;
    chk("irq_cleared", irq, 0);
    sendFrame(3'd7, ST_ARMING, 1'b0);
    streamRange(0, 7, 3'd7, ST_MOTION, 1'b1);
    irq_clr = 1'b1;
    applyStimulus(1'b0, 2'd0, 1'd0);
    chk("irq_set_wins", irq, IRQ_EN);
    applyStimulus(1'b0, 2'd0, 1'd0);
    irq_clr = 1'b0;
    chk("irq_clr_after_set", irq, 0);

    $display("[TB] async reset mid-frame");
    streamRange(0, 3, 3'd1, ST_WARMUP, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("async_state", state_o, ST_WARMUP);
    chk("async_motion", motion, 0);
    chk("async_last_cnt", last_cnt, 0);
    chk("async_irq", irq, 0);
    @(negedge clk);
    pix_valid = 1'b0;
    reset     = 1'b0;
    @(negedge clk);

    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
